serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/half_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/half_subtractor.sv
// Combinational half-subtractor: difference and borrow of x - y.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b), LSB first, with start/done handshake.
// Optional signed-overflow flag port `ovf` enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             last;
    logic             d1, bo1, d, bo2, bo;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;
`endif

    // Full-subtractor cell: two half-subtractors plus an OR of their borrows.
    half_subtractor u_hs0 (
        .x  (sa[0]),
        .y  (sb[0]),
        .d  (d1),
        .bo (bo1)
    );

    half_subtractor u_hs1 (
        .x  (d1),
        .y  (br),
        .d  (d),
        .bo (bo2)
    );

    assign bo       = bo1 | bo2;
    assign last     = (cnt == CW'(WIDTH - 1));
    assign res_next = {d, res};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they align with the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            busy <= (state_n == RUN);
            done <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= 1'b0;
                        cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_next[WIDTH-1:1];
                    br  <= bo;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        diff   <= res_next;
                        borrow <= bo;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8); ovf checks only with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] last_diff = '0;
    logic         last_borrow = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned r;
        r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
        return W'(r);
    endfunction

    function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, r;
        sx = (int'(x) >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
        sy = (int'(y) >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
        r  = sx - sy;
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'(m_diff(va, vb)));
        check({tag, "_borrow"}, 32'(borrow), 32'(m_borrow(va, vb)));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf(va, vb)));
`endif
        last_diff   = m_diff(va, vb);
        last_borrow = m_borrow(va, vb);
    endtask

    // One accept, then WIDTH busy cycles, a one-cycle done, and a drop of done.
    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        start = 1'b1; a = va; b = vb;
        for (int c = 1; c <= int'(W); c++) begin
            @(negedge clk);
            start = 1'b0; a = W'($urandom); b = W'($urandom);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        check_result(tag, va, vb);
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] qa, qb;

        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("d100_37", 8'd100, 8'd37);
        run_op("d37_100", 8'd37, 8'd100);
        run_op("d0_1", 8'd0, 8'd1);
        run_op("d255_255", 8'd255, 8'd255);
        run_op("ovf_80_01", 8'h80, 8'h01);
        run_op("ovf_05_03", 8'h05, 8'h03);

        for (int i = 0; i < 16; i++) begin
            run_op("rand", W'($urandom), W'($urandom));
        end

        // start held high with operands changing every cycle
        @(negedge clk);
        start = 1'b1;
        qa = W'($urandom); qb = W'($urandom);
        a = qa; b = qb;
        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c <= int'(W) + 1; c++) begin
                @(negedge clk);
                a = W'($urandom); b = W'($urandom);
                if (c <= int'(W)) check("hold_nodone", 32'(done), 32'd0);
            end
            check_result("hold", qa, qb);
            @(negedge clk);
            check("hold_done_drop", 32'(done), 32'd0);
            qa = W'($urandom); qb = W'($urandom);
            a = qa; b = qb;
        end
        // The final (qa, qb) were accepted at the next edge; let that op finish.
        for (int c = 1; c <= int'(W) + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_result("hold_last", qa, qb);

        // stability with start low
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom);
            check("stable_done", 32'(done), 32'd0);
            check("stable_diff", 32'(diff), 32'(last_diff));
            check("stable_borrow", 32'(borrow), 32'(last_borrow));
        end

        // reset mid-RUN discards the operation
        run_op("pre_rst", 8'd90, 8'd3);
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("midrst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < int'(W) + 4; c++) begin
            @(negedge clk);
            check("postrst_nodone", 32'(done), 32'd0);
            check("postrst_idle", 32'(busy), 32'd0);
        end
        run_op("after_rst", 8'd200, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
